// File: rtl/window_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module   : window_mask_gen
//  Purpose  : Registered ARRAY_DIM-bit mask, ONE inside a run-time programmable
//             [start,stop) index window and ZERO elsewhere. Modes: OFF, WINDOW,
//             SWEEP (window slides one position every STEP_DIV clocks, with
//             wrap-around) and TAIL (window plus every bit above stop).
//             INVERT flips the output polarity.
//  Ports    : clk, rst          clock, asynchronous active-high reset
//             i_cfg_valid       config request
//             o_cfg_ready       config accept (low while frozen)
//             i_cfg_start       window start index
//             i_cfg_stop        window stop index (exclusive)
//             i_cfg_mode        00 OFF, 01 WINDOW, 10 SWEEP, 11 TAIL
//             i_freeze          hold all state, block config
//             o_cfg_err         sticky invalid-config flag
//             o_sweep_wrap      one-cycle pulse when start wraps to 0
//             o_data            registered mask
//  Revision : 1.0  initial release
// ============================================================================
module window_mask_gen #(
    parameter  int ARRAY_DIM = 16,
    parameter  int STEP_DIV  = 4,
    parameter  int INVERT    = 0,
    localparam int IDX_W     = $clog2(ARRAY_DIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [IDX_W-1:0]     i_cfg_start,
    input  logic [IDX_W-1:0]     i_cfg_stop,
    input  logic [1:0]           i_cfg_mode,
    input  logic                 i_freeze,
    output logic                 o_cfg_err,
    output logic                 o_sweep_wrap,
    output logic [ARRAY_DIM-1:0] o_data
);

    localparam logic [1:0] c_OFF    = 2'b00;
    localparam logic [1:0] c_WINDOW = 2'b01;
    localparam logic [1:0] c_SWEEP  = 2'b10;
    localparam logic [1:0] c_TAIL   = 2'b11;

    localparam int                   c_DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0]   c_DIV_TC = c_DIV_W'(STEP_DIV - 1);
    localparam logic [IDX_W-1:0]     c_LAST   = IDX_W'(ARRAY_DIM - 1);
    localparam logic [ARRAY_DIM-1:0] c_IDLE   = (INVERT != 0) ? {ARRAY_DIM{1'b1}} : '0;

    logic [1:0]           r_state,  w_state_nxt;
    logic [IDX_W-1:0]     r_start,  w_start_nxt;
    logic [IDX_W-1:0]     r_stop,   w_stop_nxt;
    logic [c_DIV_W-1:0]   r_div,    w_div_nxt;
    logic                 r_cfg_err, w_err_nxt;
    logic                 r_wrap,   w_wrap_nxt;
    logic [ARRAY_DIM-1:0] r_data;

    logic                 w_accept;
    logic                 w_cfg_ok;
    logic                 w_ordered;
    logic [ARRAY_DIM-1:0] w_in;
    logic [ARRAY_DIM-1:0] w_above;
    logic [ARRAY_DIM-1:0] w_mask;

    assign w_accept  = i_cfg_valid & ~i_freeze;
    // Integer compare keeps the stop bound meaningful for non-power-of-2 widths.
    assign w_cfg_ok  = (i_cfg_start <= i_cfg_stop) && (int'(i_cfg_stop) < ARRAY_DIM);
    assign w_ordered = (r_start <= r_stop);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state / datapath next ----------------
    always_comb begin : p_next
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_stop_nxt  = r_stop;
        w_div_nxt   = r_div;
        w_err_nxt   = r_cfg_err;
        w_wrap_nxt  = 1'b0;
        if (!i_freeze) begin
            if (w_accept && w_cfg_ok) begin
                // A new config overrides any shift due on the same edge.
                w_state_nxt = i_cfg_mode;
                w_start_nxt = i_cfg_start;
                w_stop_nxt  = i_cfg_stop;
                w_div_nxt   = '0;
                w_err_nxt   = 1'b0;
            end else begin
                if (w_accept) begin
                    w_err_nxt = 1'b1;
                end
                if (r_state == c_SWEEP) begin
                    if (r_div == c_DIV_TC) begin
                        w_div_nxt   = '0;
                        w_start_nxt = (r_start == c_LAST) ? '0 : r_start + IDX_W'(1);
                        w_stop_nxt  = (r_stop  == c_LAST) ? '0 : r_stop  + IDX_W'(1);
                        w_wrap_nxt  = (r_start == c_LAST);
                    end else begin
                        w_div_nxt = r_div + c_DIV_W'(1);
                    end
                end
            end
        end
    end

    // ---------------- output decode ----------------
    always_comb begin : p_member
        w_in    = '0;
        w_above = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            // Once a sweep carries stop past the end, start > stop denotes a wrapped window.
            if (w_ordered) begin
                w_in[i] = (i >= int'(r_start)) && (i < int'(r_stop));
            end else begin
                w_in[i] = (i >= int'(r_start)) || (i < int'(r_stop));
            end
            w_above[i] = w_ordered && (i > int'(r_stop));
        end
    end

    always_comb begin : p_out
        w_mask = '0;
        case (r_state)
            c_WINDOW, c_SWEEP: w_mask = w_in;
            c_TAIL:            w_mask = w_in | w_above;
            default:           w_mask = '0;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start   <= '0;
            r_stop    <= '0;
            r_div     <= '0;
            r_cfg_err <= 1'b0;
            r_wrap    <= 1'b0;
            r_data    <= c_IDLE;
        end else begin
            r_start   <= w_start_nxt;
            r_stop    <= w_stop_nxt;
            r_div     <= w_div_nxt;
            r_cfg_err <= w_err_nxt;
            r_wrap    <= w_wrap_nxt;
            if (!i_freeze) begin
                r_data <= (INVERT != 0) ? ~w_mask : w_mask;
            end
        end
    end

    assign o_cfg_ready  = ~i_freeze;
    assign o_cfg_err    = r_cfg_err;
    assign o_sweep_wrap = r_wrap & ~i_freeze;
    assign o_data       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_window_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_mask_gen
//  Purpose  : Scoreboard bench for window_mask_gen. Stimulus pushes expected
//             values tagged with the cycle they are due; a monitor on the
//             falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_mask_gen;

    localparam int c_K_D1 = 0, c_K_E1 = 1, c_K_W1 = 2, c_K_R1 = 3;
    localparam int c_K_D2 = 4, c_K_W2 = 5, c_K_E2 = 6;

    localparam logic [1:0] c_OFF = 2'b00, c_WIN = 2'b01, c_SWP = 2'b10, c_TAIL = 2'b11;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        cfg_valid, freeze;
    logic [3:0]  cfg_start, cfg_stop;
    logic [1:0]  cfg_mode;
    logic        ready1, err1, wrap1;
    logic [15:0] data1;
    logic        ready2, err2, wrap2;
    logic [9:0]  data2;

    window_mask_gen #(.ARRAY_DIM(16), .STEP_DIV(4), .INVERT(0)) u_dut1 (
        .clk(clk), .rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(ready1),
        .i_cfg_start(cfg_start), .i_cfg_stop(cfg_stop), .i_cfg_mode(cfg_mode),
        .i_freeze(freeze), .o_cfg_err(err1), .o_sweep_wrap(wrap1), .o_data(data1)
    );

    window_mask_gen #(.ARRAY_DIM(10), .STEP_DIV(4), .INVERT(1)) u_dut2 (
        .clk(clk), .rst(rst2), .i_cfg_valid(cfg_valid), .o_cfg_ready(ready2),
        .i_cfg_start(cfg_start), .i_cfg_stop(cfg_stop), .i_cfg_mode(cfg_mode),
        .i_freeze(freeze), .o_cfg_err(err2), .o_sweep_wrap(wrap2), .o_data(data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            c_K_D1:  return "data16";
            c_K_E1:  return "cfg_err16";
            c_K_W1:  return "sweep_wrap16";
            c_K_R1:  return "cfg_ready16";
            c_K_D2:  return "data10inv";
            c_K_W2:  return "sweep_wrap10inv";
            default: return "cfg_err10inv";
        endcase
    endfunction

    function automatic logic [15:0] actual(int k);
        case (k)
            c_K_D1:  return data1;
            c_K_E1:  return {15'd0, err1};
            c_K_W1:  return {15'd0, wrap1};
            c_K_R1:  return {15'd0, ready1};
            c_K_D2:  return {6'd0, data2};
            c_K_W2:  return {15'd0, wrap2};
            default: return {15'd0, err2};
        endcase
    endfunction

    // Insert keeping the queue ordered by due cycle.
    function automatic void expect_at(int d, int k, logic [15:0] v);
        exp_t e;
        int   idx;
        e.cyc  = cyc + d;
        e.kind = k;
        e.val  = v;
        idx    = q.size();
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc > e.cyc) idx = i;
        end
        q.insert(idx, e);
    endfunction

    always @(negedge clk) begin : p_monitor
        exp_t        e;
        logic [15:0] a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            a = actual(e.kind);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%h expected=%h", kname(e.kind), e.cyc, a, e.val);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic cfg(logic [1:0] m, logic [3:0] s, logic [3:0] e);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cfg_start = s;
        cfg_stop  = e;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        cfg_valid = 1'b0; freeze = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_mode = c_OFF;
        tick(3);
        rst = 1'b0;
        expect_at(0, c_K_D1, 16'h0000);
        expect_at(0, c_K_E1, 16'd0);
        expect_at(0, c_K_W1, 16'd0);
        expect_at(0, c_K_R1, 16'd1);
        tick(1);

        // WINDOW 4/9: one-cycle latency after acceptance
        expect_at(1, c_K_D1, 16'h0000);
        expect_at(1, c_K_E1, 16'd0);
        expect_at(2, c_K_D1, 16'h01F0);
        cfg(c_WIN, 4'd4, 4'd9);
        tick(2);

        // TAIL 4/9, then rejected 5/3, then WINDOW 0/1 clears the error
        expect_at(2, c_K_D1, 16'hFDF0);
        cfg(c_TAIL, 4'd4, 4'd9);
        expect_at(1, c_K_E1, 16'd1);
        expect_at(2, c_K_D1, 16'hFDF0);
        expect_at(4, c_K_D1, 16'hFDF0);
        cfg(c_WIN, 4'd5, 4'd3);
        tick(3);
        expect_at(1, c_K_E1, 16'd0);
        expect_at(2, c_K_D1, 16'h0001);
        cfg(c_WIN, 4'd0, 4'd1);
        tick(2);

        // SWEEP 14/15 with wrap; a rejected config mid-sweep leaves it running
        expect_at(2,  c_K_D1, 16'h4000);
        expect_at(5,  c_K_D1, 16'h4000);
        expect_at(6,  c_K_D1, 16'h8000);
        expect_at(9,  c_K_D1, 16'h8000);
        expect_at(8,  c_K_W1, 16'd0);
        expect_at(9,  c_K_W1, 16'd1);
        expect_at(10, c_K_W1, 16'd0);
        expect_at(10, c_K_D1, 16'h0001);
        expect_at(14, c_K_D1, 16'h0002);
        expect_at(4,  c_K_E1, 16'd1);
        cfg(c_SWP, 4'd14, 4'd15);
        tick(2);
        cfg(c_WIN, 4'd5, 4'd3);
        tick(11);

        // SWEEP 2/5 frozen for 10 cycles; config offered during freeze is ignored
        expect_at(1,  c_K_E1, 16'd0);
        expect_at(2,  c_K_D1, 16'h001C);
        expect_at(3,  c_K_D1, 16'h001C);
        expect_at(5,  c_K_R1, 16'd0);
        expect_at(8,  c_K_D1, 16'h001C);
        expect_at(14, c_K_R1, 16'd1);
        expect_at(14, c_K_E1, 16'd0);
        expect_at(15, c_K_D1, 16'h001C);
        expect_at(16, c_K_D1, 16'h0038);
        cfg(c_SWP, 4'd2, 4'd5);
        tick(2);
        freeze = 1'b1;
        cfg_valid = 1'b1; cfg_mode = c_WIN; cfg_start = 4'd5; cfg_stop = 4'd3;
        tick(10);
        freeze = 1'b0;
        cfg_valid = 1'b0;
        tick(4);

        // Config on the sweep terminal count wins over the shift; then OFF
        expect_at(2, c_K_D1, 16'h0003);
        expect_at(5, c_K_D1, 16'h0003);
        expect_at(6, c_K_D1, 16'h0300);
        expect_at(9, c_K_D1, 16'h0300);
        cfg(c_SWP, 4'd0, 4'd2);
        tick(3);
        cfg(c_WIN, 4'd8, 4'd10);
        tick(5);
        expect_at(2, c_K_D1, 16'h0000);
        cfg(c_OFF, 4'd0, 4'd0);
        tick(2);

        // ARRAY_DIM=10, INVERT=1: wrap at 10, then async reset mid-sweep
        rst2 = 1'b0;
        expect_at(0,  c_K_D2, 16'h03FF);
        expect_at(0,  c_K_E2, 16'd0);
        expect_at(0,  c_K_W2, 16'd0);
        expect_at(2,  c_K_D2, 16'h02FF);
        expect_at(5,  c_K_D2, 16'h02FF);
        expect_at(6,  c_K_D2, 16'h01FF);
        expect_at(9,  c_K_D2, 16'h01FF);
        expect_at(9,  c_K_W2, 16'd1);
        expect_at(10, c_K_D2, 16'h03FE);
        cfg(c_SWP, 4'd8, 4'd9);
        tick(10);
        expect_at(0, c_K_D2, 16'h03FF);
        rst2 = 1'b1;
        tick(2);
        rst2 = 1'b0;
        expect_at(0, c_K_D2, 16'h03FF);
        expect_at(0, c_K_W2, 16'd0);
        expect_at(3, c_K_D2, 16'h03FF);
        tick(5);

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
